// File: rtl/lcd_pkg.sv
// Shared types, character constants and helpers for the LCD line formatter.
package lcd_pkg;

    localparam int unsigned LCD_COLS  = 16;
    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned LINE_W    = LCD_COLS * CHAR_W;
    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_QMARK = 8'h3F;

    typedef logic [LINE_W-1:0] line_t;

    localparam line_t BLANK_LINE = {LCD_COLS{CHAR_SPACE}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } fmt_state_t;

    // Map one nibble to its ASCII hex digit, upper or lower case letters.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nibble, input logic upper);
        logic [7:0] base;
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        base = upper ? 8'h41 : 8'h61;
        return base + {4'h0, nibble} - 8'd10;
    endfunction

    // Replace non-printable bytes so the panel never receives control codes.
    function automatic logic [7:0] sanitize_char(input logic [7:0] c);
        return ((c < 8'h20) || (c > 8'h7E)) ? CHAR_QMARK : c;
    endfunction

endpackage

// File: rtl/lcd_line_formatter.sv
// Renders "label: XXXXXXXX" lines one hex digit per clock and commits them atomically.
module lcd_line_formatter
    import lcd_pkg::*;
#(
    parameter bit HEX_UPPER   = 1'b1,
    parameter bit BLANK_ZEROS = 1'b0
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_line,
    input  logic [31:0] req_label,
    input  logic [31:0] req_value,
    output line_t       line1_buffer,
    output line_t       line2_buffer,
    output logic [1:0]  line_updated
);

    fmt_state_t  state_q;
    logic        line_sel_q;
    logic [31:0] value_q;
    logic [2:0]  digit_k_q;
    logic        blank_q;
    line_t       work_q;
    line_t       line1_q;
    line_t       line2_q;
    logic [1:0]  updated_q;
    logic        ready_q;

    logic [3:0]  nibble_c;
    logic        digit_blank_c;
    logic [7:0]  digit_char_c;
    logic [6:0]  digit_lsb_c;

    // Current digit: value is shifted left so the next nibble is always at the top.
    always_comb begin
        nibble_c      = value_q[31:28];
        digit_blank_c = blank_q && (nibble_c == 4'h0) && (digit_k_q != 3'd7);
        digit_char_c  = digit_blank_c ? CHAR_SPACE : hex2ascii(nibble_c, HEX_UPPER);
        // Column 6+k sits at byte (15-(6+k)) from the LSB end.
        digit_lsb_c   = {4'd9 - {1'b0, digit_k_q}, 3'b000};
    end

    // Request accept, per-digit rendering and atomic commit.
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            line_sel_q <= 1'b0;
            value_q    <= '0;
            digit_k_q  <= '0;
            blank_q    <= 1'b0;
            work_q     <= BLANK_LINE;
            line1_q    <= BLANK_LINE;
            line2_q    <= BLANK_LINE;
            updated_q  <= '0;
            ready_q    <= 1'b0;
        end else begin
            updated_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid && ready_q) begin
                        line_sel_q <= req_line;
                        value_q    <= req_value;
                        digit_k_q  <= '0;
                        blank_q    <= BLANK_ZEROS;
                        work_q     <= {sanitize_char(req_label[31:24]),
                                       sanitize_char(req_label[23:16]),
                                       sanitize_char(req_label[15:8]),
                                       sanitize_char(req_label[7:0]),
                                       CHAR_COLON, CHAR_SPACE,
                                       {10{CHAR_SPACE}}};
                        ready_q    <= 1'b0;
                        state_q    <= CONV;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                CONV: begin
                    work_q[digit_lsb_c +: 8] <= digit_char_c;
                    value_q   <= {value_q[27:0], 4'h0};
                    digit_k_q <= digit_k_q + 3'd1;
                    if (!digit_blank_c) begin
                        blank_q <= 1'b0;
                    end
                    if (digit_k_q == 3'd7) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (line_sel_q) begin
                        line2_q   <= work_q;
                        updated_q <= 2'b10;
                    end else begin
                        line1_q   <= work_q;
                        updated_q <= 2'b01;
                    end
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = ready_q;
    assign line1_buffer = line1_q;
    assign line2_buffer = line2_q;
    assign line_updated = updated_q;

endmodule
